// File: rtl/bit_walker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bit_walker_pkg
//  Description : Shared types and helpers for the bit_walker block.
//                state_t  - walk FSM state encoding
//                onehot() - one-hot mask for a bit index inside a w-bit word
//  Revision    : 1.0 - initial release
// ============================================================================
package bit_walker_pkg;

    // Upper bound on supported word width; onehot() returns this many bits and
    // callers size-cast the result down to their own width.
    localparam int unsigned MAX_W  = 1024;
    localparam int unsigned MAX_LW = $clog2(MAX_W);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WALK = 1'b1
    } state_t;

    // Bit idx set, all others clear; indices outside the w-bit word yield zero.
    function automatic logic [MAX_W-1:0] onehot(input int unsigned idx,
                                                input int unsigned w);
        logic [MAX_W-1:0] r;
        r = '0;
        if ((idx < w) && (idx < MAX_W)) begin
            r[idx[MAX_LW-1:0]] = 1'b1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bit_walker_if.sv
`default_nettype none
// ============================================================================
//  Module      : bit_walker_if
//  Description : Input-word and output-beat handshake bundle of bit_walker.
//                in_vld_i/in_rdy_o/in_x_i/in_pos_i   : word to walk + start pos
//                out_vld_o/out_rdy_i/out_idx_o/out_seq_o/out_last_o/out_empty_o
//                                                    : one set-bit index per beat
//                slave  : the walker side
//                master : the producer/consumer side
//  Revision    : 1.0 - initial release
// ============================================================================
interface bit_walker_if #(
    parameter int unsigned W = 32
);
    localparam int unsigned LW = $clog2(W);

    logic          in_vld_i;
    logic          in_rdy_o;
    logic [W-1:0]  in_x_i;
    logic [LW-1:0] in_pos_i;

    logic          out_vld_o;
    logic          out_rdy_i;
    logic [LW-1:0] out_idx_o;
    logic [LW:0]   out_seq_o;
    logic          out_last_o;
    logic          out_empty_o;

    modport slave (
        input  in_vld_i, in_x_i, in_pos_i, out_rdy_i,
        output in_rdy_o, out_vld_o, out_idx_o, out_seq_o, out_last_o, out_empty_o
    );

    modport master (
        output in_vld_i, in_x_i, in_pos_i, out_rdy_i,
        input  in_rdy_o, out_vld_o, out_idx_o, out_seq_o, out_last_o, out_empty_o
    );

endinterface
`default_nettype wire

// File: rtl/bit_walker_scan.sv
`default_nettype none
// ============================================================================
//  Module      : bit_walker_scan
//  Description : Combinational circular priority scan. Returns the first set
//                bit of x_i at an index >= pos_i, wrapping W-1 -> 0.
//                x_i   in  W   word to scan
//                pos_i in  LW  start position
//                any_o out 1   x_i has at least one set bit
//                idx_o out LW  found index (0 when x_i is zero)
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_walker_scan #(
    parameter int unsigned W = 32
) (
    input  wire logic [W-1:0]          x_i,
    input  wire logic [$clog2(W)-1:0]  pos_i,
    output logic                       any_o,
    output logic [$clog2(W)-1:0]       idx_o
);
    localparam int unsigned LW = $clog2(W);

    // Walk offsets from farthest to nearest so the nearest hit wins.
    // W is a power of two, so the LW-bit add wraps modulo W for free.
    always_comb begin
        logic [LW-1:0] k;
        k     = '0;
        any_o = |x_i;
        idx_o = '0;
        for (int i = W - 1; i >= 0; i--) begin
            k = pos_i + LW'(i);
            if (x_i[k]) begin
                idx_o = k;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bit_walker.sv
`default_nettype none
// ============================================================================
//  Module      : bit_walker
//  Description : Emits the indices of the set bits of a W-bit word, one per
//                output beat, ascending and circular from a start position.
//                clk    in  clock
//                arst_n in  asynchronous active-low reset
//                bus    slave modport of bit_walker_if (word in, beats out)
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_walker
    import bit_walker_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  wire logic   clk,
    input  wire logic   arst_n,
    bit_walker_if.slave bus
);
    localparam int unsigned LW = $clog2(W);
    localparam int unsigned SW = LW + 1;

    state_t        state_q, state_d;
    logic [LW-1:0] idx_q,   idx_d;
    logic [W-1:0]  rem_q,   rem_d;
    logic [SW-1:0] seq_q,   seq_d;
    logic          last_q,  last_d;
    logic          empty_q, empty_d;

    logic          out_vld;
    logic          in_rdy;
    logic          in_hs;
    logic          out_hs;
    logic [W-1:0]  scan_x;
    logic [LW-1:0] scan_pos;
    logic          scan_any;
    logic [LW-1:0] scan_idx;
    logic [W-1:0]  scan_rem;

    assign out_vld = (state_q == WALK);
    // A new word may enter in the same cycle the final beat leaves.
    assign in_rdy  = (state_q == IDLE) | (out_vld & bus.out_rdy_i & last_q);
    assign in_hs   = bus.in_vld_i & in_rdy;
    assign out_hs  = out_vld & bus.out_rdy_i;

    // One scanner shared between load and advance; load wins, and the two
    // only coincide on a last beat where advance has nothing left to do.
    assign scan_x   = in_hs ? bus.in_x_i   : rem_q;
    assign scan_pos = in_hs ? bus.in_pos_i : idx_q + LW'(1);

    bit_walker_scan #(.W(W)) u_scan (
        .x_i   (scan_x),
        .pos_i (scan_pos),
        .any_o (scan_any),
        .idx_o (scan_idx)
    );

    // Scanned word with the chosen bit removed: the remainder after this beat.
    assign scan_rem = scan_x & ~W'(onehot(32'(scan_idx), W));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        seq_d   = seq_q;
        last_d  = last_q;
        empty_d = empty_q;
        case (state_q)
            IDLE: begin
                if (in_hs) begin
                    state_d = WALK;
                end
            end
            WALK: begin
                if (out_hs && last_q && !in_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (in_hs) begin
            idx_d   = scan_idx;
            rem_d   = scan_rem;
            seq_d   = '0;
            last_d  = (scan_rem == '0);
            empty_d = ~scan_any;
        end else if (out_hs && !last_q) begin
            idx_d   = scan_idx;
            rem_d   = scan_rem;
            seq_d   = seq_q + SW'(1);
            last_d  = (scan_rem == '0);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rem_q   <= '0;
            seq_q   <= '0;
            last_q  <= 1'b0;
            empty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            seq_q   <= seq_d;
            last_q  <= last_d;
            empty_q <= empty_d;
        end
    end

    assign bus.in_rdy_o    = in_rdy;
    assign bus.out_vld_o   = out_vld;
    assign bus.out_idx_o   = idx_q;
    assign bus.out_seq_o   = seq_q;
    assign bus.out_last_o  = last_q;
    assign bus.out_empty_o = empty_q;

endmodule
`default_nettype wire

// File: tb/tb_bit_walker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bit_walker
//  Description : Self-checking bench for bit_walker at W=8. Isolated words are
//                driven from a vector table; stall, back-to-back and
//                reset-abort cases are hand-written sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bit_walker;

    localparam int unsigned W = 8;

    logic clk    = 1'b0;
    logic arst_n = 1'b0;

    always #5 clk = ~clk;

    bit_walker_if #(.W(W)) bus();

    bit_walker #(.W(W)) u_dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    // idxs packs the expected index of beat k in bits [3k+2:3k].
    typedef struct packed {
        logic [7:0]  x;
        logic [2:0]  pos;
        logic [3:0]  n;
        logic        empty;
        logic [23:0] idxs;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_beat(input string nm, input logic [2:0] idx, input int seq,
                              input logic last, input logic empty);
        chk({nm, " vld"},   32'(bus.out_vld_o),   32'd1);
        chk({nm, " idx"},   32'(bus.out_idx_o),   32'(idx));
        chk({nm, " seq"},   32'(bus.out_seq_o),   32'(seq));
        chk({nm, " last"},  32'(bus.out_last_o),  32'(last));
        chk({nm, " empty"}, 32'(bus.out_empty_o), 32'(empty));
    endtask

    // Accept one word from IDLE with out_rdy held high, then check every beat.
    task automatic run_word(input string nm, input logic [7:0] x, input logic [2:0] pos,
                            input int n, input logic empty, input logic [23:0] idxs);
        chk({nm, " in_rdy idle"}, 32'(bus.in_rdy_o), 32'd1);
        bus.in_vld_i  = 1'b1;
        bus.in_x_i    = x;
        bus.in_pos_i  = pos;
        bus.out_rdy_i = 1'b1;
        step();
        bus.in_vld_i = 1'b0;
        bus.in_x_i   = 8'hA5;
        for (int k = 0; k < n; k++) begin
            check_beat($sformatf("%s beat%0d", nm, k), idxs[3*k +: 3], k, (k == n - 1), empty);
            step();
        end
        chk({nm, " vld after last"}, 32'(bus.out_vld_o), 32'd0);
    endtask

    initial begin
        tbl[0] = '{x: 8'b1001_0010, pos: 3'd3, n: 4'd3, empty: 1'b0,
                   idxs: {15'd0, 3'd1, 3'd7, 3'd4}};
        tbl[1] = '{x: 8'h00, pos: 3'd5, n: 4'd1, empty: 1'b1,
                   idxs: 24'd0};
        tbl[2] = '{x: 8'hFF, pos: 3'd7, n: 4'd8, empty: 1'b0,
                   idxs: {3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7}};
        tbl[3] = '{x: 8'h01, pos: 3'd4, n: 4'd1, empty: 1'b0,
                   idxs: {21'd0, 3'd0}};
        tbl[4] = '{x: 8'h80, pos: 3'd0, n: 4'd1, empty: 1'b0,
                   idxs: {21'd0, 3'd7}};
        tbl[5] = '{x: 8'h81, pos: 3'd7, n: 4'd2, empty: 1'b0,
                   idxs: {18'd0, 3'd0, 3'd7}};

        bus.in_vld_i  = 1'b0;
        bus.in_x_i    = 8'h00;
        bus.in_pos_i  = 3'd0;
        bus.out_rdy_i = 1'b1;

        // Reset state
        #12;
        chk("rst vld",    32'(bus.out_vld_o),   32'd0);
        chk("rst idx",    32'(bus.out_idx_o),   32'd0);
        chk("rst seq",    32'(bus.out_seq_o),   32'd0);
        chk("rst last",   32'(bus.out_last_o),  32'd0);
        chk("rst empty",  32'(bus.out_empty_o), 32'd0);
        step();
        arst_n = 1'b1;
        #1;
        chk("rst in_rdy", 32'(bus.in_rdy_o), 32'd1);
        step();

        // Isolated words
        for (int v = 0; v < 6; v++) begin
            run_word($sformatf("vec%0d", v), tbl[v].x, tbl[v].pos, int'(tbl[v].n),
                     tbl[v].empty, tbl[v].idxs);
        end

        // Stall at seq 1 for 3 cycles: idx 5 must hold, stream 0,5,6 intact
        bus.in_vld_i  = 1'b1;
        bus.in_x_i    = 8'b0110_0001;
        bus.in_pos_i  = 3'd0;
        bus.out_rdy_i = 1'b1;
        step();
        bus.in_vld_i = 1'b0;
        check_beat("stall b0", 3'd0, 0, 1'b0, 1'b0);
        step();
        bus.out_rdy_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_beat($sformatf("stall hold%0d", c), 3'd5, 1, 1'b0, 1'b0);
            chk($sformatf("stall in_rdy%0d", c), 32'(bus.in_rdy_o), 32'd0);
            step();
        end
        bus.out_rdy_i = 1'b1;
        check_beat("stall b1", 3'd5, 1, 1'b0, 1'b0);
        step();
        check_beat("stall b2", 3'd6, 2, 1'b1, 1'b0);
        step();
        chk("stall done vld", 32'(bus.out_vld_o), 32'd0);

        // Back-to-back: second word accepted on first word's last handshake
        bus.in_vld_i = 1'b1;
        bus.in_x_i   = 8'h03;
        bus.in_pos_i = 3'd0;
        step();
        bus.in_x_i   = 8'h04;
        bus.in_pos_i = 3'd0;
        #1;
        check_beat("b2b A0", 3'd0, 0, 1'b0, 1'b0);
        chk("b2b in_rdy A0", 32'(bus.in_rdy_o), 32'd0);
        step();
        check_beat("b2b A1", 3'd1, 1, 1'b1, 1'b0);
        chk("b2b in_rdy A1", 32'(bus.in_rdy_o), 32'd1);
        step();
        bus.in_vld_i = 1'b0;
        check_beat("b2b B0", 3'd2, 0, 1'b1, 1'b0);
        step();
        chk("b2b done vld", 32'(bus.out_vld_o), 32'd0);

        // Reset mid-walk aborts the stream; next word starts clean
        bus.in_vld_i = 1'b1;
        bus.in_x_i   = 8'hF0;
        bus.in_pos_i = 3'd0;
        step();
        bus.in_vld_i = 1'b0;
        check_beat("abort b0", 3'd4, 0, 1'b0, 1'b0);
        #2;
        arst_n = 1'b0;
        #1;
        chk("abort vld",  32'(bus.out_vld_o), 32'd0);
        chk("abort idx",  32'(bus.out_idx_o), 32'd0);
        chk("abort seq",  32'(bus.out_seq_o), 32'd0);
        step();
        step();
        arst_n = 1'b1;
        #1;
        chk("abort in_rdy", 32'(bus.in_rdy_o), 32'd1);
        step();
        run_word("after_rst", 8'h01, 3'd4, 1, 1'b0, 24'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
